// File: rtl/demux_1_to_2_stream.sv
// -----------------------------------------------------------------------------
// demux_1_to_2_stream
//
// Routes one valid/ready word stream to one of two valid/ready outputs in
// fixed-length bursts. The destination is sampled from `selector` on the first
// beat of a burst. It is then held until BurstLen beats have been accepted, so
// a burst never straddles both outputs. Each output has a one-entry register
// stage, which gives one clock of latency from accept to output valid. The two
// output stages drain independently of each other.
//
// Parameters
//   DWidth     data word width
//   BurstLen   beats per burst (>= 1)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   selector    destination of the next burst (0 -> m0, 1 -> m1)
//   s_valid     input word valid
//   s_ready     input word can be accepted
//   s_data      input word
//   m0_valid    output 0 word valid
//   m0_ready    output 0 consumer ready
//   m0_data     output 0 word
//   m1_valid    output 1 word valid
//   m1_ready    output 1 consumer ready
//   m1_data     output 1 word
//   busy        high while a burst is in progress (ROUTE state)
//   burst_done  one-cycle pulse in the cycle after a burst's final accept
//   burst_dst   destination of the most recently completed burst
// -----------------------------------------------------------------------------
module demux_1_to_2_stream #(
    parameter int DWidth   = 32,
    parameter int BurstLen = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              selector,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWidth-1:0] s_data,
    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DWidth-1:0] m0_data,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [DWidth-1:0] m1_data,
    output logic              busy,
    output logic              burst_done,
    output logic              burst_dst
);

    localparam int CntW = $clog2(BurstLen + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BurstLen - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic              dst_q_reg, dst_q_next;
    logic [CntW-1:0]   cnt_reg, cnt_next;
    logic              done_reg, done_next;
    logic              burst_dst_reg, burst_dst_next;

    logic              dst;
    logic              accept;

    // Output stage arrays, index = destination.
    logic [1:0]        out_valid_reg;
    logic [DWidth-1:0] out_data_reg [2];
    logic [1:0]        out_ready;
    logic [1:0]        out_load;

    assign out_ready = {m1_ready, m0_ready};

    // While idle the destination follows selector so the first beat of a burst
    // goes straight to the right output; mid-burst it is frozen.
    assign dst = (state_reg == IDLE) ? selector : dst_q_reg;

    // Ready looks only at the chosen output stage, never at s_valid.
    assign s_ready = !out_valid_reg[dst] || out_ready[dst];
    assign accept  = s_valid && s_ready;

    // -------------------------------------------------------------------------
    // Burst FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dst_q_reg     <= 1'b0;
            cnt_reg       <= '0;
            done_reg      <= 1'b0;
            burst_dst_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dst_q_reg     <= dst_q_next;
            cnt_reg       <= cnt_next;
            done_reg      <= done_next;
            burst_dst_reg <= burst_dst_next;
        end
    end

    // -------------------------------------------------------------------------
    // Burst FSM: next state, beat counter, completion pulse
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        dst_q_next     = dst_q_reg;
        cnt_next       = cnt_reg;
        done_next      = 1'b0;
        burst_dst_next = burst_dst_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    dst_q_next = selector;
                    if (BurstLen == 1) begin
                        // Single-beat bursts complete on their first accept.
                        done_next      = 1'b1;
                        burst_dst_next = selector;
                        cnt_next       = '0;
                    end else begin
                        cnt_next   = CntW'(1);
                        state_next = ROUTE;
                    end
                end
            end
            ROUTE: begin
                if (accept) begin
                    if (cnt_reg == LastCnt) begin
                        done_next      = 1'b1;
                        burst_dst_next = dst_q_reg;
                        cnt_next       = '0;
                        state_next     = IDLE;
                    end else begin
                        cnt_next = cnt_reg + CntW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output register stages, one per destination
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_out
            assign out_load[gi] = accept && (dst == 1'(gi));

            // A load wins over a drain, so a simultaneous drain and load keeps
            // valid high with the new word. Data only changes on a load, which
            // can only happen when the stage is empty or being drained. This
            // keeps the data stable while the stage is stalled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_reg[gi] <= 1'b0;
                    out_data_reg[gi]  <= '0;
                end else begin
                    if (out_load[gi]) begin
                        out_valid_reg[gi] <= 1'b1;
                        out_data_reg[gi]  <= s_data;
                    end else if (out_ready[gi]) begin
                        out_valid_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign m0_valid   = out_valid_reg[0];
    assign m0_data    = out_data_reg[0];
    assign m1_valid   = out_valid_reg[1];
    assign m1_data    = out_data_reg[1];
    assign busy       = (state_reg == ROUTE);
    assign burst_done = done_reg;
    assign burst_dst  = burst_dst_reg;

endmodule
